// File: rtl/cpu_strap_sampler.sv
// ---------------------------------------------------------------------------
// cpu_strap_sampler
//  Synchronizes, settles and stability-qualifies the raw CPU socket straps
//  after aux power is good, and presents one latched strap set plus a valid
//  flag. Downstream logic must only evaluate the straps while oStrapValid=1.
//
//  Packed strap vector S[13:0] =
//    {SktOcc_n[1:0], Intr[1:0], ProcID2[1:0], ProcID1[1:0], PkgID2[2:0], PkgID1[2:0]}
//
//  Ports
//    iClk, iRst            clock, asynchronous active-low reset
//    iAuxPwrDone           aux rail good; low returns to IDLE
//    iResample             one-cycle pulse, drop lock and requalify
//    *Raw inputs           asynchronous raw straps (14 bits total)
//    onvCPUSktOcc, ovIntr, ovProcIDCPU1/2, ovPkgIDCPU1/2   latched straps
//    oStrapValid           latched set is qualified
//    oStrapUnstable        sample budget exhausted without lock (sticky)
//    oStrapChanged         one-cycle pulse when synced straps leave the
//                          latched set while locked
//
//  Build option CPU_STRAP_OVERRIDE_EN adds iOvrEn / ivOvrStrap, a
//  synchronous override of the strap outputs; the FSM keeps running.
//
//  state  | meaning
//  IDLE   | aux power not good, outputs at reset values
//  SETTLE | waiting SETTLE_CYCLES for straps to settle
//  SAMPLE | sampling every SAMPLE_GAP cycles, counting matches/tries
//  LOCKED | strap set latched and valid, watching for divergence
//  FAIL   | no stable set within MAX_TRIES samples
// ---------------------------------------------------------------------------
module cpu_strap_sampler #(
   parameter logic [15:0] SETTLE_CYCLES = 16'd2000,
   parameter logic [7:0]  SAMPLE_GAP    = 8'd8,
   parameter logic [3:0]  SAMPLES       = 4'd4,
   parameter logic [7:0]  MAX_TRIES     = 8'd32
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iAuxPwrDone,
   input  logic        iResample,
   input  logic [1:0]  invCPUSktOccRaw,
   input  logic [1:0]  ivIntrRaw,
   input  logic [1:0]  ivProcIDCPU1Raw,
   input  logic [1:0]  ivProcIDCPU2Raw,
   input  logic [2:0]  ivPkgIDCPU1Raw,
   input  logic [2:0]  ivPkgIDCPU2Raw,
`ifdef CPU_STRAP_OVERRIDE_EN
   input  logic        iOvrEn,
   input  logic [13:0] ivOvrStrap,
`endif
   output logic [1:0]  onvCPUSktOcc,
   output logic [1:0]  ovIntr,
   output logic [1:0]  ovProcIDCPU1,
   output logic [1:0]  ovProcIDCPU2,
   output logic [2:0]  ovPkgIDCPU1,
   output logic [2:0]  ovPkgIDCPU2,
   output logic        oStrapValid,
   output logic        oStrapUnstable,
   output logic        oStrapChanged
);

   // Sockets read as empty (active-low occupied) when nothing is qualified.
   localparam logic [13:0] STRAP_RST = 14'h3C00;

   typedef enum logic [2:0] {
      ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_LOCKED, ST_FAIL
   } state_t;

   state_t      state;
   logic [13:0] rawStrap, syncQ1, syncQ2, refStrap, latStrap;
   logic [15:0] settleCnt;
   logic [7:0]  gapCnt;
   logic [3:0]  matchCnt;
   logic [7:0]  triesCnt;
   logic        valid, unstable, changed, chgArmed;

   logic        firstSample;
   logic [3:0]  matchNext;
   logic [7:0]  triesNext;

   assign rawStrap = {invCPUSktOccRaw, ivIntrRaw, ivProcIDCPU2Raw, ivProcIDCPU1Raw,
                      ivPkgIDCPU2Raw, ivPkgIDCPU1Raw};

   // matchCnt==0 marks "no reference yet"; the first sample is not a try.
   assign firstSample = (matchCnt == 4'd0);

   always_comb begin
      matchNext = 4'd1;
      if (!firstSample && (syncQ2 == refStrap))
         matchNext = (matchCnt == 4'hF) ? matchCnt : matchCnt + 4'd1;
      triesNext = triesCnt;
      if (!firstSample && (triesCnt != 8'hFF))
         triesNext = triesCnt + 8'd1;
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state     <= ST_IDLE;
         syncQ1    <= STRAP_RST;
         syncQ2    <= STRAP_RST;
         refStrap  <= '0;
         latStrap  <= STRAP_RST;
         settleCnt <= '0;
         gapCnt    <= '0;
         matchCnt  <= '0;
         triesCnt  <= '0;
         valid     <= 1'b0;
         unstable  <= 1'b0;
         changed   <= 1'b0;
         chgArmed  <= 1'b1;
      end else begin
         syncQ1  <= rawStrap;
         syncQ2  <= syncQ1;
         changed <= 1'b0;
         if (!iAuxPwrDone) begin
            state     <= ST_IDLE;
            latStrap  <= STRAP_RST;
            settleCnt <= '0;
            gapCnt    <= '0;
            matchCnt  <= '0;
            triesCnt  <= '0;
            valid     <= 1'b0;
            unstable  <= 1'b0;
            chgArmed  <= 1'b1;
         end else if (iResample && (state != ST_IDLE)) begin
            // Straps keep their last values; only the qualification restarts.
            state     <= ST_SETTLE;
            settleCnt <= SETTLE_CYCLES - 16'd1;
            gapCnt    <= '0;
            matchCnt  <= '0;
            triesCnt  <= '0;
            valid     <= 1'b0;
            unstable  <= 1'b0;
            chgArmed  <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  state     <= ST_SETTLE;
                  settleCnt <= SETTLE_CYCLES - 16'd1;
               end
               ST_SETTLE: begin
                  if (settleCnt == 16'd0) begin
                     state  <= ST_SAMPLE;
                     gapCnt <= '0;
                  end else begin
                     settleCnt <= settleCnt - 16'd1;
                  end
               end
               ST_SAMPLE: begin
                  if (gapCnt != 8'd0) begin
                     gapCnt <= gapCnt - 8'd1;
                  end else begin
                     gapCnt   <= SAMPLE_GAP - 8'd1;
                     refStrap <= syncQ2;
                     matchCnt <= matchNext;
                     triesCnt <= triesNext;
                     // Lock wins over exhaustion on the same sample.
                     if (matchNext >= SAMPLES) begin
                        state    <= ST_LOCKED;
                        latStrap <= syncQ2;
                        chgArmed <= 1'b1;
                     end else if (!firstSample && (triesNext >= MAX_TRIES)) begin
                        state    <= ST_FAIL;
                        latStrap <= STRAP_RST;
                        unstable <= 1'b1;
                     end
                  end
               end
               ST_LOCKED: begin
                  valid <= 1'b1;
                  // One pulse per divergence episode; re-armed on re-match.
                  if (syncQ2 != latStrap) begin
                     changed  <= chgArmed;
                     chgArmed <= 1'b0;
                  end else begin
                     chgArmed <= 1'b1;
                  end
               end
               ST_FAIL: begin
                  valid    <= 1'b0;
                  unstable <= 1'b1;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef CPU_STRAP_OVERRIDE_EN
   logic        ovrEnQ;
   logic [13:0] ovrStrapQ;

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         ovrEnQ    <= 1'b0;
         ovrStrapQ <= '0;
      end else begin
         ovrEnQ    <= iOvrEn;
         ovrStrapQ <= ivOvrStrap;
      end
   end

   assign {onvCPUSktOcc, ovIntr, ovProcIDCPU2, ovProcIDCPU1, ovPkgIDCPU2, ovPkgIDCPU1} =
          ovrEnQ ? ovrStrapQ : latStrap;
   assign oStrapValid    = ovrEnQ | valid;
   assign oStrapChanged  = changed & ~ovrEnQ;
   assign oStrapUnstable = unstable;
`else
   assign {onvCPUSktOcc, ovIntr, ovProcIDCPU2, ovProcIDCPU1, ovPkgIDCPU2, ovPkgIDCPU1} = latStrap;
   assign oStrapValid    = valid;
   assign oStrapChanged  = changed;
   assign oStrapUnstable = unstable;
`endif

endmodule
